// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding, command record and width helper for the RAM arbiter
package ram_arb_pkg;
  localparam int CMD_ADDR_W = 30;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_HOLD} state_t;
  typedef struct packed {
    logic                  we;
    logic [3:0]            be;
    logic [CMD_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic                  lock;
  } cmd_t;
  function automatic int word_bits(input int addr_bits);
    return addr_bits - 2;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick with optional absolute priority for a holding owner
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  input  logic hold_owner_valid,
  input  logic owner,
  output logic grant_valid,
  output logic winner
);
  logic owner_req;
  assign owner_req = owner ? req1 : req0;
  assign grant_valid = req0 | req1;
  assign winner = (hold_owner_valid && owner_req) ? owner : (req0 && req1) ? ~last_owner : req1;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port sequencer with bounded locked bursts in front of the data RAM
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LOCK_MAX  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [3:0]           be0,
  input  logic [3:0]           be1,
  input  logic [ADDR_BITS-3:0] addr0,
  input  logic [ADDR_BITS-3:0] addr1,
  input  logic [31:0]          wdata0,
  input  logic [31:0]          wdata1,
  input  logic                 lock0,
  input  logic                 lock1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [31:0]          rdata0,
  output logic [31:0]          rdata1,
  output logic                 ram_rw,
  output logic [3:0]           ram_sel,
  output logic [ADDR_BITS-3:0] ram_addr,
  output logic [31:0]          ram_data_in,
  input  logic [31:0]          ram_data_out
);
  localparam int WB = word_bits(ADDR_BITS);
  localparam int LW = $clog2(LOCK_MAX + 1);
  state_t          state, state_n;
  logic            owner, owner_n, last_owner, last_n;
  logic [LW-1:0]   lock_cnt, cnt_n;
  cmd_t            cmd, cmd_n;
  logic            grant_valid, winner, acc, cmd_unused;
  rr_pick2 u_pick (
    .req0             (req0),
    .req1             (req1),
    .last_owner       (last_owner),
    .hold_owner_valid (state == ST_HOLD),
    .owner            (owner),
    .grant_valid      (grant_valid),
    .winner           (winner)
  );
  // state, ownership and latched command; reset aborts any in-flight access immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lock_cnt   <= '0;
      cmd        <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_n;
      lock_cnt   <= cnt_n;
      cmd        <= cmd_n;
    end
  end
  // ACCESS always drops out for a cycle so a stale req at the ack edge is never re-granted
  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last_owner;
    cnt_n   = lock_cnt;
    cmd_n   = cmd;
    if (state == ST_ACCESS) begin
      state_n = (cmd.lock && lock_cnt < LW'(LOCK_MAX)) ? ST_HOLD : ST_IDLE;
    end else if (grant_valid) begin
      state_n = ST_ACCESS;
      owner_n = winner;
      last_n  = winner;
      cnt_n   = (state == ST_HOLD && winner == owner) ? lock_cnt + LW'(1) : LW'(1);
      cmd_n   = '0;
      cmd_n.we    = winner ? we1 : we0;
      cmd_n.be    = winner ? be1 : be0;
      cmd_n.addr[WB-1:0] = winner ? addr1 : addr0;
      cmd_n.wdata = winner ? wdata1 : wdata0;
      cmd_n.lock  = winner ? lock1 : lock0;
    end
  end
  assign acc         = state == ST_ACCESS;
  assign cmd_unused  = ^cmd.addr;
  assign ack0        = acc & ~owner;
  assign ack1        = acc & owner;
  assign ram_rw      = acc & cmd.we;
  assign ram_sel     = acc ? cmd.be : 4'h0;
  assign ram_addr    = acc ? cmd.addr[WB-1:0] : '0;
  assign ram_data_in = acc ? cmd.wdata : 32'h0;
  assign rdata0      = (ack0 && !cmd.we) ? ram_data_out : 32'h0;
  assign rdata1      = (ack1 && !cmd.we) ? ram_data_out : 32'h0;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the word-addressed data RAM: port 0 = pipeline MEM stage, port 1 = loader/debug DMA.
- Arbitrates round-robin, latches the winner's command and drives the RAM's single access port for exactly one cycle.
- Returns ack plus read data to the winner.
- Supports bounded locked bursts so the loader can stream words without losing the port after every beat.

Parameters:
- ADDR_BITS, 12, byte address width of the RAM; the word address is ADDR_BITS-2 bits.
- LOCK_MAX, 4, maximum consecutive locked accesses by one owner before forced release; must be ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request; held until the matching ack
- we0 / we1  in  1  1=write, 0=read
- be0 / be1  in  4  byte enables; bit i = byte lane [8i+7:8i]
- addr0 / addr1  in  ADDR_BITS-2  word address
- wdata0 / wdata1  in  32  write data
- lock0 / lock1  in  1  request to keep ownership after this access
- ack0 / ack1  out  1  access performed this cycle
- rdata0 / rdata1  out  32  read data, valid while the matching ack is high
- ram_rw  out  1  to RAM: 1=write
- ram_sel  out  4  to RAM byte enables
- ram_addr  out  ADDR_BITS-2  to RAM word address
- ram_data_in  out  32  to RAM write data
- ram_data_out  in  32  from RAM: combinational read, pre-masked by sel and ~rw

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- States: IDLE, ACCESS, HOLD.
- Registers: state, owner (1b), last_owner (1b), lock_cnt (clog2(LOCK_MAX+1) bits), and latched cmd {we, be, addr, wdata, lock}.
- Reset values:
  - state=IDLE, owner=0, last_owner=1 (port 0 wins the first tie), lock_cnt=0, cmd=0.
  - All outputs 0.
  - Reset takes effect immediately with no clock edge, including mid-ACCESS; an aborted write is not committed.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_owner.
  - On grant: latch that port's cmd, set owner and last_owner to the winner, set lock_cnt=1, go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - ram_rw=cmd.we, ram_sel=cmd.be, ram_addr=cmd.addr, ram_data_in=cmd.wdata.
  - ack[owner]=1. rdata[owner]=ram_data_out when the cmd is a read, else 0.
  - The write commits at the clock edge ending ACCESS.
  - Next state: HOLD if cmd.lock and lock_cnt<LOCK_MAX, else IDLE.
- HOLD:
  - Same as IDLE, except the owner's req has absolute priority.
  - If the owner requests: latch, set lock_cnt+=1, go to ACCESS.
  - If the owner does not request: perform normal IDLE arbitration this same cycle and set lock_cnt=1 on any grant.
- Forced release: when lock_cnt reaches LOCK_MAX, return to IDLE. Because last_owner=owner, a waiting other port wins the next grant.
- Outside ACCESS:
  - ram_rw=0, ram_sel=0, ram_addr=0, ram_data_in=0.
  - ack0=ack1=0, rdata0=rdata1=0.
- Output derivation: all outputs are decoded from registers only (state, owner, cmd) plus ram_data_out for rdata. There are no combinational paths from req/addr to the RAM.
- Latency and throughput:
  - An uncontended access acks 2 cycles after req is first seen in IDLE (grant edge, then the ACCESS cycle).
  - Sustained throughput is 1 access per 2 cycles.
  - ACCESS is never directly followed by ACCESS, because a stale req at the ack edge must not be re-granted.
- Requester protocol:
  - Inputs are sampled only at the grant edge; changes after the grant are ignored for that access.
  - The requester drops or replaces req in the cycle after its ack.
- be=0000 is legal: the write changes nothing and a read returns 0.
- Simultaneous lock from both ports: lock applies only to the current owner; the other port's lock is ignored until it owns the port.

Decomposition:
- Shared package, ram_arb_pkg:
  - state encoding constants ST_IDLE, ST_ACCESS, ST_HOLD.
  - word-address width function.
  - command struct {we, be, addr, wdata, lock}.
- Sub-module rr_pick2: 2-way round-robin pick from (req0, req1, last_owner, hold_owner_valid, owner) → {grant_valid, winner}. It is purely combinational and reused by the future I-side arbiter.

Test Plan:
1. After reset, p0 writes addr=5, wdata=0xDEADBEEF, be=1111 → ack0 in the 2nd cycle with ram_rw=1, ram_sel=F, ram_addr=5. A following p0 read of addr 5 → ack0 with rdata0=0xDEADBEEF and ram_rw=0.
2. req0 and req1 rise in the same cycle after reset → ack0 at cycle +2, ack1 at cycle +4. ack1 never overlaps ack0.
3. Both ports request continuously, no locks, for 8 accesses → ack order 0,1,0,1,… with exactly one ack per 2 cycles.
4. LOCK_MAX=4, p1 requests continuously with lock1=1 while p0 requests continuously → four consecutive ack1, then ack0, then p1 again.
5. Word 9 preloaded with 0x11223344, then p1 writes be=0010, wdata=0x0000AB00 → a p0 full-word read of addr 9 returns 0x1122AB44.
6. rst pulsed mid-ACCESS on a write of 0xCAFEF00D to addr 3, between clock edges → ack and ram_rw fall immediately. A later read of addr 3 does not return 0xCAFEF00D. After reset, a tie grants p0 first.
